// File: rtl/axis_bram_writer_pkg.sv
// -----------------------------------------------------------------------------
// axis_bram_writer_pkg
//
// Shared definitions for the AXI4-Stream to BRAM capture block:
//   - state_t       : capture FSM encoding (IDLE / RUN / DONE)
//   - we_all_ones() : builds an all-ones byte-enable mask of a given width
// -----------------------------------------------------------------------------
package axis_bram_writer_pkg;

    // Encoding is fixed so the state can be decoded by software or a debug
    // probe without a lookup table.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WE_MASK_MAX = 128;

    // All-ones mask of 'n' bits, right-aligned in a WE_MASK_MAX-bit word.
    // The caller casts the result down to its own byte-enable width.
    function automatic logic [WE_MASK_MAX-1:0] we_all_ones(input int n);
        logic [WE_MASK_MAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < WE_MASK_MAX; i++) begin
            if (i < n) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage : axis_bram_writer_pkg

// File: rtl/axis_bram_writer.sv
// -----------------------------------------------------------------------------
// axis_bram_writer
//
// AXI4-Stream slave that captures a block of stream words into a BRAM through
// a simple registered write port. A single-cycle start strobe arms a capture
// of cfg_data+1 words (one-shot mode) or a ring-buffer capture that wraps at
// the limit (continuous mode). tlast terminates a one-shot capture early, or
// re-aligns the ring to address 0 in continuous mode.
//
// Parameters
//   AXIS_TDATA_WIDTH : slave stream data width
//   BRAM_DATA_WIDTH  : BRAM word width (tdata truncated or zero-extended)
//   BRAM_ADDR_WIDTH  : BRAM address width
//   CONTINUOUS       : "TRUE" = ring-buffer capture, "FALSE" = stop at limit
//
// Ports
//   aclk, areset         : clock, asynchronous active-high reset
//   cfg_data             : last address to write; sampled on cfg_start
//   cfg_start            : single-cycle start strobe (ignored while running)
//   sts_data             : next write address
//   sts_done             : high while the capture is complete
//   s_axis_*             : AXI4-Stream slave (tready, tdata, tvalid, tlast)
//   bram_porta_*         : BRAM write port (clk, rst, addr, wrdata, we)
// -----------------------------------------------------------------------------
module axis_bram_writer
    import axis_bram_writer_pkg::*;
#(
    parameter int    AXIS_TDATA_WIDTH = 32,
    parameter int    BRAM_DATA_WIDTH  = 32,
    parameter int    BRAM_ADDR_WIDTH  = 10,
    parameter string CONTINUOUS       = "FALSE"
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic [BRAM_ADDR_WIDTH-1:0]    cfg_data,
    input  logic                          cfg_start,
    output logic [BRAM_ADDR_WIDTH-1:0]    sts_data,
    output logic                          sts_done,

    output logic                          s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,

    output logic                          bram_porta_clk,
    output logic                          bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]    bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]    bram_porta_wrdata,
    output logic [BRAM_DATA_WIDTH/8-1:0]  bram_porta_we
);

    localparam int                WE_WIDTH = BRAM_DATA_WIDTH / 8;
    localparam logic [WE_WIDTH-1:0] WE_ALL = WE_WIDTH'(we_all_ones(WE_WIDTH));
    localparam bit                IS_CONT  = (CONTINUOUS == "TRUE");

    state_t                     state;
    logic [BRAM_ADDR_WIDTH-1:0] addr;
    logic [BRAM_ADDR_WIDTH-1:0] limit;

    logic                       beat;
    logic                       at_end;
    logic [BRAM_DATA_WIDTH-1:0] data_fit;

    // Upper tdata bits are dropped when the BRAM word is narrower.
    logic                       unused_tdata;
    assign unused_tdata = ^s_axis_tdata;

    // BRAM port shares the stream clock and reset.
    assign bram_porta_clk = aclk;
    assign bram_porta_rst = areset;

    // Ready decodes the state register only, so there is no combinational
    // path from tvalid back to tready.
    assign s_axis_tready = (state == ST_RUN);
    assign sts_done      = (state == ST_DONE);
    assign sts_data      = addr;

    assign beat     = s_axis_tvalid && s_axis_tready;
    assign at_end   = (addr == limit) || s_axis_tlast;
    // Sized cast truncates to the LSBs or zero-extends as needed.
    assign data_fit = BRAM_DATA_WIDTH'(s_axis_tdata);

    // -------------------------------------------------------------------------
    // Capture FSM: state, running address and latched limit.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
            addr  <= '0;
            limit <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start) begin
                        state <= ST_RUN;
                        limit <= cfg_data;
                        addr  <= '0;
                    end
                end

                ST_RUN: begin
                    if (beat) begin
                        if (at_end && IS_CONT) begin
                            // Ring mode: wrap (or re-align on tlast) and keep going.
                            addr <= '0;
                        end else begin
                            // Wraps naturally when limit is the top address.
                            addr <= addr + 1'b1;
                            if (at_end) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end

                // NOTE: the unused encoding recovers to IDLE; unassigned
                // registers simply hold, which is fine in a clocked block
                // (latches only arise from incomplete combinational logic).
                default: state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registered BRAM write port: one cycle behind the accepted beat.
    // -------------------------------------------------------------------------
    // NOTE: these are the only write-path registers and they are reset so an
    // in-flight write is cancelled the moment areset asserts; the BRAM array
    // itself is never cleared.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bram_porta_addr   <= '0;
            bram_porta_wrdata <= '0;
            bram_porta_we     <= '0;
        end else begin
            if (beat) begin
                bram_porta_addr   <= addr;
                bram_porta_wrdata <= data_fit;
                bram_porta_we     <= WE_ALL;
            end else begin
                bram_porta_we     <= '0;
            end
        end
    end

endmodule : axis_bram_writer

// File: tb/tb_axis_bram_writer.sv
// -----------------------------------------------------------------------------
// tb_axis_bram_writer
//
// Directed bench for axis_bram_writer. Two instances share clock and reset:
// dut (one-shot capture) and dut_c (continuous ring capture). Each has a
// small BRAM model that records what its write port commits.
// -----------------------------------------------------------------------------
module tb_axis_bram_writer;

    localparam int          AW       = 10;
    localparam int          DW       = 32;
    localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;
    localparam logic [3:0]  WE_ON    = 4'hF;

    logic clk;
    logic rst;

    // One-shot instance signals
    logic [AW-1:0] cfg_data;
    logic          cfg_start;
    logic [AW-1:0] sts_data;
    logic          sts_done;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          p_clk;
    logic          p_rst;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wrdata;
    logic [3:0]    p_we;

    // Continuous instance signals
    logic [AW-1:0] cfg_data_c;
    logic          cfg_start_c;
    logic [AW-1:0] sts_data_c;
    logic          sts_done_c;
    logic          tready_c;
    logic [DW-1:0] tdata_c;
    logic          tvalid_c;
    logic          tlast_c;
    logic          p_clk_c;
    logic          p_rst_c;
    logic [AW-1:0] p_addr_c;
    logic [DW-1:0] p_wrdata_c;
    logic [3:0]    p_we_c;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem   [1 << AW];
    logic [DW-1:0] mem_c [1 << AW];
    logic          mem_clr;

    axis_bram_writer #(
        .AXIS_TDATA_WIDTH (DW),
        .BRAM_DATA_WIDTH  (DW),
        .BRAM_ADDR_WIDTH  (AW),
        .CONTINUOUS       ("FALSE")
    ) dut (
        .aclk              (clk),
        .areset            (rst),
        .cfg_data          (cfg_data),
        .cfg_start         (cfg_start),
        .sts_data          (sts_data),
        .sts_done          (sts_done),
        .s_axis_tready     (tready),
        .s_axis_tdata      (tdata),
        .s_axis_tvalid     (tvalid),
        .s_axis_tlast      (tlast),
        .bram_porta_clk    (p_clk),
        .bram_porta_rst    (p_rst),
        .bram_porta_addr   (p_addr),
        .bram_porta_wrdata (p_wrdata),
        .bram_porta_we     (p_we)
    );

    axis_bram_writer #(
        .AXIS_TDATA_WIDTH (DW),
        .BRAM_DATA_WIDTH  (DW),
        .BRAM_ADDR_WIDTH  (AW),
        .CONTINUOUS       ("TRUE")
    ) dut_c (
        .aclk              (clk),
        .areset            (rst),
        .cfg_data          (cfg_data_c),
        .cfg_start         (cfg_start_c),
        .sts_data          (sts_data_c),
        .sts_done          (sts_done_c),
        .s_axis_tready     (tready_c),
        .s_axis_tdata      (tdata_c),
        .s_axis_tvalid     (tvalid_c),
        .s_axis_tlast      (tlast_c),
        .bram_porta_clk    (p_clk_c),
        .bram_porta_rst    (p_rst_c),
        .bram_porta_addr   (p_addr_c),
        .bram_porta_wrdata (p_wrdata_c),
        .bram_porta_we     (p_we_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: commit on the BRAM port clock when all byte lanes enabled.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i]   <= SENTINEL;
                mem_c[i] <= SENTINEL;
            end
        end else begin
            if (p_we == WE_ON)   mem[p_addr]     <= p_wrdata;
            if (p_we_c == WE_ON) mem_c[p_addr_c] <= p_wrdata_c;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic [AW-1:0] lim);
        cfg_data  = lim;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic start_c(input logic [AW-1:0] lim);
        cfg_data_c  = lim;
        cfg_start_c = 1'b1;
        tick();
        cfg_start_c = 1'b0;
    endtask

    task automatic beat_c(input logic [DW-1:0] d, input logic l);
        tvalid_c = 1'b1;
        tdata_c  = d;
        tlast_c  = l;
        tick();
        tvalid_c = 1'b0;
        tlast_c  = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;

        rst         = 1'b1;
        mem_clr     = 1'b1;
        cfg_data    = '0;
        cfg_start   = 1'b0;
        tdata       = '0;
        tvalid      = 1'b1;   // held high from the start: must not be accepted
        tlast       = 1'b0;
        cfg_data_c  = '0;
        cfg_start_c = 1'b0;
        tdata_c     = '0;
        tvalid_c    = 1'b0;
        tlast_c     = 1'b0;

        // ---------------- Reset values ----------------
        repeat (3) tick();
        mem_clr = 1'b0;
        check("rst_tready",   tready,   1'b0);
        check("rst_done",     sts_done, 1'b0);
        check("rst_sts_data", sts_data, 10'd0);
        check("rst_we",       p_we,     4'h0);
        check("rst_addr",     p_addr,   10'd0);
        check("rst_wrdata",   p_wrdata, 32'h0);
        check("rst_tready_c", tready_c, 1'b0);
        check("rst_port_rst", p_rst,    1'b1);
        rst = 1'b0;

        // ---------------- Idle with tvalid held, no start ----------------
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_tready",   tready,   1'b0);
            check("idle_we",       p_we,     4'h0);
            check("idle_sts_data", sts_data, 10'd0);
        end
        tvalid = 1'b0;

        // ---------------- Single capture, limit 7 ----------------
        start(10'd7);
        cfg_data = 10'd2;   // change during RUN must be ignored
        check("cap_tready", tready,   1'b1);
        check("cap_done0",  sts_done, 1'b0);
        check("cap_sts0",   sts_data, 10'd0);
        for (int i = 0; i < 8; i++) begin
            beat(32'h100 + 32'(i), 1'b0);
            check("cap_we",     p_we,     WE_ON);
            check("cap_paddr",  p_addr,   AW'(i));
            check("cap_wrdata", p_wrdata, 32'h100 + 32'(i));
            check("cap_sts",    sts_data, AW'(i + 1));
        end
        check("cap_done",      sts_done, 1'b1);
        check("cap_tready_lo", tready,   1'b0);
        tvalid = 1'b1;
        tdata  = 32'h1FF;
        tick();
        check("cap_9th_we0",  p_we,     4'h0);
        check("cap_sts_hold", sts_data, 10'd8);
        tick();
        check("cap_9th_we1",  p_we,     4'h0);
        tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("cap_mem", mem[i], 32'h100 + 32'(i));
        end
        check("cap_mem8_untouched", mem[8], SENTINEL);

        // ---------------- Early tlast, limit 15 ----------------
        start(10'd15);
        check("tl_done0", sts_done, 1'b0);
        check("tl_sts0",  sts_data, 10'd0);
        for (int i = 0; i < 4; i++) begin
            beat(32'h200 + 32'(i), (i == 3));
        end
        check("tl_done",   sts_done, 1'b1);
        check("tl_sts",    sts_data, 10'd4);
        check("tl_tready", tready,   1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("tl_mem", mem[i], 32'h200 + 32'(i));
        end
        check("tl_mem4_old", mem[4], 32'h104);

        // ---------------- Bubbles, limit 3 ----------------
        start(10'd3);
        check("bub_done0", sts_done, 1'b0);
        check("bub_sts0",  sts_data, 10'd0);
        pat = 7'b1101001;   // step i valid = pat[i]: 1,0,0,1,0,1,1
        for (int i = 0; i < 7; i++) begin
            tvalid = pat[i];
            tdata  = 32'h300 + 32'(i);
            tick();
            check("bub_we", p_we, pat[i] ? WE_ON : 4'h0);
        end
        tvalid = 1'b0;
        check("bub_done", sts_done, 1'b1);
        check("bub_sts",  sts_data, 10'd4);
        tick();
        check("bub_mem0", mem[0], 32'h300);
        check("bub_mem1", mem[1], 32'h303);
        check("bub_mem2", mem[2], 32'h305);
        check("bub_mem3", mem[3], 32'h306);

        // ---------------- Reset mid-RUN with a write in flight ----------------
        start(10'd7);
        for (int i = 0; i < 3; i++) begin
            beat(32'h400 + 32'(i), 1'b0);
        end
        tvalid = 1'b1;
        tdata  = 32'h403;
        tick();
        tvalid = 1'b0;
        check("mr_we_inflight",   p_we,   WE_ON);
        check("mr_addr_inflight", p_addr, 10'd3);
        #2 rst = 1'b1;
        #1;
        check("mr_we_async",  p_we,     4'h0);
        check("mr_addr",      p_addr,   10'd0);
        check("mr_wrdata",    p_wrdata, 32'h0);
        check("mr_sts",       sts_data, 10'd0);
        check("mr_tready",    tready,   1'b0);
        check("mr_done",      sts_done, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("mr_mem", mem[i], 32'h400 + 32'(i));
        end
        check("mr_mem3_not_written", mem[3], 32'h306);
        rst = 1'b0;
        start(10'd1);
        check("mr2_sts0", sts_data, 10'd0);
        beat(32'h500, 1'b0);
        beat(32'h501, 1'b0);
        check("mr2_done", sts_done, 1'b1);
        check("mr2_sts",  sts_data, 10'd2);
        tick();
        check("mr2_mem0", mem[0], 32'h500);
        check("mr2_mem1", mem[1], 32'h501);

        // ---------------- Continuous ring, limit 3 ----------------
        start_c(10'd3);
        check("ring_tready0", tready_c, 1'b1);
        for (int i = 0; i < 10; i++) begin
            beat_c(32'(i), 1'b0);
            check("ring_tready", tready_c, 1'b1);
        end
        check("ring_sts",  sts_data_c, 10'd2);
        check("ring_done", sts_done_c, 1'b0);
        beat_c(32'd10, 1'b1);   // lands at addr 2, tlast re-aligns to 0
        check("ring_mem0", mem_c[0], 32'd8);
        check("ring_mem1", mem_c[1], 32'd9);
        check("ring_mem2", mem_c[2], 32'd6);
        check("ring_mem3", mem_c[3], 32'd7);
        check("ring_tlast_sts", sts_data_c, 10'd0);
        beat_c(32'd11, 1'b0);
        check("ring_sts_after", sts_data_c, 10'd1);
        tick();
        check("ring_mem0_b", mem_c[0], 32'd11);
        check("ring_mem2_b", mem_c[2], 32'd10);
        check("ring_done_b", sts_done_c, 1'b0);
        check("ring_tready_b", tready_c, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_axis_bram_writer

// File: doc/axis_bram_writer.md
Name: axis_bram_writer

Overview:
AXI4-Stream slave that captures a block of stream words into a BRAM through a simple write port. It is the capture-side counterpart of the BRAM-to-stream reader and sits between a stream source (ADC/DSP chain) and a BRAM that is later read back by the PS or a reader core. A start pulse arms one capture of cfg_data+1 words, or continuous ring-buffer capture. Status reports the current write address and completion.

Parameters:
AXIS_TDATA_WIDTH, 32, slave stream data width
BRAM_DATA_WIDTH, 32, BRAM word width; tdata truncated to LSBs or zero-extended
BRAM_ADDR_WIDTH, 10, BRAM address width
CONTINUOUS, "FALSE", "TRUE": wrap to 0 at limit and keep capturing; "FALSE": stop at limit

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
cfg_data  in  BRAM_ADDR_WIDTH  last address to write (limit); latched at start
cfg_start  in  1  single-cycle start strobe
sts_data  out  BRAM_ADDR_WIDTH  next write address
sts_done  out  1  high in DONE state
s_axis_tready  out  1  slave ready
s_axis_tdata  in  AXIS_TDATA_WIDTH  slave data
s_axis_tvalid  in  1  slave valid
s_axis_tlast  in  1  end of packet
bram_porta_clk  out  1  = aclk
bram_porta_rst  out  1  = areset
bram_porta_addr  out  BRAM_ADDR_WIDTH  registered write address
bram_porta_wrdata  out  BRAM_DATA_WIDTH  registered write data
bram_porta_we  out  BRAM_DATA_WIDTH/8  registered byte enables, all-ones or all-zeros

Behaviour:
- Reset (async assert, release sync to aclk): state IDLE, addr=0, limit=0, sts_data=0, sts_done=0, s_axis_tready=0, bram_porta_addr=0, wrdata=0, we=0.
- States IDLE, RUN, DONE. s_axis_tready = (state==RUN), decoded from state register only (no combinational path from tvalid).
- IDLE/DONE: cfg_start=1 -> RUN next cycle; limit<=cfg_data, addr<=0, sts_done<=0. cfg_start ignored in RUN.
- RUN beat = tvalid & tready. Each beat: next cycle we=all-ones, bram_porta_addr=addr, wrdata=tdata (1-cycle write latency); we=0 on non-beat cycles. addr increments by 1 per beat.
- End condition on a beat: addr==limit OR tlast=1.
  - CONTINUOUS="FALSE": state -> DONE, tready low from next cycle, sts_done=1, addr holds last+1 (mod 2^BRAM_ADDR_WIDTH).
  - CONTINUOUS="TRUE": addr -> 0, stay RUN; never enters DONE. tlast re-aligns the ring to 0.
- Limit=0: exactly one word captured. Limit=2^BRAM_ADDR_WIDTH-1: addr increment wraps to 0 naturally; no overflow flag.
- tvalid low stalls with no writes and no address change; the beat count is unaffected by bubbles.
- sts_data = addr register (one cycle ahead of the BRAM write currently on the port).
- cfg_data changes during RUN have no effect until the next start.
- Reset mid-RUN: pending registered write is cleared asynchronously (we=0 immediately); no partial state survives.

Decomposition:
- Package axis_bram_writer_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the we all-ones constant helper.
- No sub-module. Single always block for state/addr/limit and one for the write-port registers.

Test Plan:
- Reset then idle: tvalid=1 held, no start -> tready=0, we=0, sts_data=0 for 20 cycles.
- Single capture, CONTINUOUS="FALSE", cfg_data=7, start, 8 back-to-back beats 0x100..0x107 -> BRAM[0..7]=0x100..0x107, sts_done=1, sts_data=8, tready=0, 9th word not written.
- Early tlast: cfg_data=15, tlast on 4th beat -> 4 words written at 0..3, DONE, sts_data=4; restart with cfg_start -> sts_done=0, addr=0.
- Bubbles: cfg_data=3, tvalid toggled 1,0,0,1,0,1,1 -> writes only on valid cycles at addresses 0..3, correct data order.
- Continuous: CONTINUOUS="TRUE", cfg_data=3, 10 beats 0..9 -> final BRAM[0..3]=8,9,6,7, sts_data=2, sts_done=0, tready stays 1.
- Reset mid-RUN after 3 beats with beat in flight -> we drops asynchronously with areset, all outputs at reset values, next start captures from address 0.
